// File: rtl/game_round_ctrl.sv
// Round sequencer for the ball-and-holes game: PLAY -> FALL animation -> SHOW result,
// then next level, retry, or game over.
module game_round_ctrl #(
  parameter int RADIUS        = 16,
  parameter int FALL_FRAMES   = 16,
  parameter int RESULT_FRAMES = 60,
  parameter int MAX_LEVEL     = 4,
  parameter int INIT_LIVES    = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_frame_tick,
  input  logic       i_win,
  input  logic       i_fail,
  input  logic [9:0] i_fall_x,
  input  logic [9:0] i_fall_y,
  input  logic [9:0] i_bl_x,
  input  logic [9:0] i_bl_y,
  output logic       o_is_game_playing,
  output logic       o_level_load,
  output logic [2:0] o_level,
  output logic [2:0] o_lives,
  output logic [2:0] o_state,
  output logic       o_result_win,
  output logic [9:0] o_anim_x,
  output logic [9:0] o_anim_y,
  output logic [4:0] o_anim_r
);

  localparam int CNT_MAX = (FALL_FRAMES > RESULT_FRAMES) ? FALL_FRAMES : RESULT_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PLAY = 3'd1,
    FALL = 3'd2,
    SHOW = 3'd3,
    OVER = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [2:0]       level, level_n;
  logic [2:0]       lives, lives_n;
  logic             result_win, result_win_n;
  logic [9:0]       anim_x, anim_x_n, anim_y, anim_y_n;
  logic [4:0]       anim_r, anim_r_n;
  logic [9:0]       tgt_x, tgt_x_n, tgt_y, tgt_y_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             level_load, level_load_n;
  logic             playing;

  // One pixel toward the target; unsigned compare so the step never wraps.
  function automatic logic [9:0] step_toward(input logic [9:0] cur, input logic [9:0] tgt);
    if (cur < tgt)      return cur + 10'd1;
    else if (cur > tgt) return cur - 10'd1;
    else                return cur;
  endfunction

  function automatic logic [4:0] sat_dec(input logic [4:0] r);
    return (r == 5'd0) ? 5'd0 : r - 5'd1;
  endfunction

  assign cnt_inc = cnt + CNT_W'(1);

  always_comb begin
    state_n      = state;
    level_n      = level;
    lives_n      = lives;
    result_win_n = result_win;
    anim_x_n     = anim_x;
    anim_y_n     = anim_y;
    anim_r_n     = anim_r;
    tgt_x_n      = tgt_x;
    tgt_y_n      = tgt_y;
    cnt_n        = cnt;
    level_load_n = 1'b0;

    case (state)
      IDLE, OVER: begin
        if (i_start) begin
          state_n      = PLAY;
          level_n      = 3'd0;
          lives_n      = 3'(INIT_LIVES);
          level_load_n = 1'b1;
        end
      end
      PLAY: begin
        if (i_win || i_fail) begin
          state_n      = FALL;
          result_win_n = i_win;
          tgt_x_n      = i_fall_x;
          tgt_y_n      = i_fall_y;
          anim_x_n     = i_bl_x;
          anim_y_n     = i_bl_y;
          cnt_n        = '0;
        end
      end
      FALL: begin
        if (i_frame_tick) begin
          anim_x_n = step_toward(anim_x, tgt_x);
          anim_y_n = step_toward(anim_y, tgt_y);
          anim_r_n = sat_dec(anim_r);
          if (cnt_inc == CNT_W'(FALL_FRAMES)) begin
            state_n = SHOW;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      SHOW: begin
        if (i_frame_tick) begin
          if (cnt_inc == CNT_W'(RESULT_FRAMES)) begin
            cnt_n = '0;
            if (result_win) begin
              if (level < 3'(MAX_LEVEL - 1)) begin
                level_n      = level + 3'd1;
                state_n      = PLAY;
                level_load_n = 1'b1;
              end else begin
                state_n = OVER;
              end
            end else if (lives > 3'd1) begin
              lives_n      = lives - 3'd1;
              state_n      = PLAY;
              level_load_n = 1'b1;
            end else begin
              lives_n = 3'd0;
              state_n = OVER;
            end
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Any cycle that lands in PLAY shows the live ball at full size.
    if (state_n == PLAY) begin
      anim_x_n = i_bl_x;
      anim_y_n = i_bl_y;
      anim_r_n = 5'(RADIUS);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= IDLE;
      level      <= 3'd0;
      lives      <= 3'(INIT_LIVES);
      result_win <= 1'b0;
      anim_x     <= 10'd0;
      anim_y     <= 10'd0;
      anim_r     <= 5'(RADIUS);
      tgt_x      <= 10'd0;
      tgt_y      <= 10'd0;
      cnt        <= '0;
      level_load <= 1'b0;
      playing    <= 1'b0;
    end else begin
      state      <= state_n;
      level      <= level_n;
      lives      <= lives_n;
      result_win <= result_win_n;
      anim_x     <= anim_x_n;
      anim_y     <= anim_y_n;
      anim_r     <= anim_r_n;
      tgt_x      <= tgt_x_n;
      tgt_y      <= tgt_y_n;
      cnt        <= cnt_n;
      level_load <= level_load_n;
      playing    <= (state_n == PLAY);
    end
  end

  assign o_state           = state;
  assign o_level           = level;
  assign o_lives           = lives;
  assign o_result_win      = result_win;
  assign o_anim_x          = anim_x;
  assign o_anim_y          = anim_y;
  assign o_anim_r          = anim_r;
  assign o_level_load      = level_load;
  assign o_is_game_playing = playing;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl: vector table, hand-written round sequences, and a
// randomized run against a closed-form round model.
module tb_game_round_ctrl;

  localparam int RADIUS        = 16;
  localparam int FALL_FRAMES   = 16;
  localparam int RESULT_FRAMES = 60;
  localparam int MAX_LEVEL     = 4;
  localparam int INIT_LIVES    = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, tick = 1'b0, win = 1'b0, fail = 1'b0;
  logic [9:0] fall_x = '0, fall_y = '0, bl_x = '0, bl_y = '0;
  logic       is_game_playing, level_load, result_win;
  logic [2:0] level, lives, state;
  logic [9:0] anim_x, anim_y;
  logic [4:0] anim_r;

  int n_checks = 0;
  int n_errors = 0;

  game_round_ctrl #(
    .RADIUS(RADIUS), .FALL_FRAMES(FALL_FRAMES), .RESULT_FRAMES(RESULT_FRAMES),
    .MAX_LEVEL(MAX_LEVEL), .INIT_LIVES(INIT_LIVES)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_frame_tick(tick),
    .i_win(win), .i_fail(fail), .i_fall_x(fall_x), .i_fall_y(fall_y),
    .i_bl_x(bl_x), .i_bl_y(bl_y),
    .o_is_game_playing(is_game_playing), .o_level_load(level_load),
    .o_level(level), .o_lives(lives), .o_state(state), .o_result_win(result_win),
    .o_anim_x(anim_x), .o_anim_y(anim_y), .o_anim_r(anim_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit start, tick, win, fail;
    int bl_x, bl_y, fall_x, fall_y, n;
    int e_state, e_play, e_load, e_level, e_lives, e_win, e_ax, e_ay, e_r;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mkv(bit s, bit t, bit w, bit f, int bx, int by, int fx, int fy, int n,
                               int es, int ep, int el, int elvl, int elv, int ew,
                               int eax, int eay, int er);
    vec_t v;
    v.start = s; v.tick = t; v.win = w; v.fail = f;
    v.bl_x = bx; v.bl_y = by; v.fall_x = fx; v.fall_y = fy; v.n = n;
    v.e_state = es; v.e_play = ep; v.e_load = el; v.e_level = elvl; v.e_lives = elv;
    v.e_win = ew; v.e_ax = eax; v.e_ay = eay; v.e_r = er;
    return v;
  endfunction

  task automatic chk(input string name, input int es, ep, el, elvl, elv, ew, eax, eay, er);
    n_checks++;
    if (int'(state) != es || int'(is_game_playing) != ep || int'(level_load) != el ||
        int'(level) != elvl || int'(lives) != elv || int'(result_win) != ew ||
        int'(anim_x) != eax || int'(anim_y) != eay || int'(anim_r) != er) begin
      n_errors++;
      $display("FAIL %s: got st=%0d play=%0d load=%0d lvl=%0d lives=%0d win=%0d anim=(%0d,%0d,r%0d) exp st=%0d play=%0d load=%0d lvl=%0d lives=%0d win=%0d anim=(%0d,%0d,r%0d)",
               name, state, is_game_playing, level_load, level, lives, result_win,
               anim_x, anim_y, anim_r, es, ep, el, elvl, elv, ew, eax, eay, er);
    end
  endtask

  task automatic chk_val(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d exp %0d", name, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 0; tick = 0; win = 0; fail = 0;
    cycles(2);
    rst = 1'b1;
  endtask

  // Assumes PLAY; flags one hole, then ticks through the whole FALL and SHOW.
  task automatic play_round(input bit w, input bit f);
    fall_x = 10'd300; fall_y = 10'd200; bl_x = 10'd290; bl_y = 10'd210;
    win = w; fail = f;
    cycles(1);
    win = 0; fail = 0; tick = 1;
    cycles(FALL_FRAMES + RESULT_FRAMES);
    tick = 0;
  endtask

  // Round model: position/radius in the fall are closed-form in the tick count.
  int m_state, m_level, m_lives, m_win, m_ax, m_ay, m_r, m_load;
  int m_sx, m_sy, m_tx, m_ty, m_ft, m_st;

  function automatic int approach(int s, int t, int n);
    if (s < t) return s + (((t - s) < n) ? (t - s) : n);
    else       return s - (((s - t) < n) ? (s - t) : n);
  endfunction

  task automatic model_reset();
    m_state = 0; m_level = 0; m_lives = INIT_LIVES; m_win = 0;
    m_ax = 0; m_ay = 0; m_r = RADIUS; m_load = 0; m_ft = 0; m_st = 0;
    m_sx = 0; m_sy = 0; m_tx = 0; m_ty = 0;
  endtask

  task automatic model_enter_play();
    m_state = 1; m_load = 1; m_ax = bl_x; m_ay = bl_y; m_r = RADIUS;
  endtask

  task automatic model_step();
    m_load = 0;
    case (m_state)
      0, 4: if (start) begin
        m_level = 0; m_lives = INIT_LIVES;
        model_enter_play();
      end
      1: begin
        m_ax = bl_x; m_ay = bl_y; m_r = RADIUS;
        if (win || fail) begin
          m_state = 2; m_win = win; m_tx = fall_x; m_ty = fall_y;
          m_sx = bl_x; m_sy = bl_y; m_ft = 0;
        end
      end
      2: if (tick) begin
        m_ft++;
        m_ax = approach(m_sx, m_tx, m_ft);
        m_ay = approach(m_sy, m_ty, m_ft);
        m_r  = (m_ft >= RADIUS) ? 0 : RADIUS - m_ft;
        if (m_ft == FALL_FRAMES) begin m_state = 3; m_st = 0; end
      end
      3: if (tick) begin
        m_st++;
        if (m_st == RESULT_FRAMES) begin
          if (m_win != 0) begin
            if (m_level < MAX_LEVEL - 1) begin m_level++; model_enter_play(); end
            else m_state = 4;
          end else if (m_lives > 1) begin
            m_lives--; model_enter_play();
          end else begin
            m_lives = 0; m_state = 4;
          end
        end
      end
      default: m_state = 0;
    endcase
  endtask

  initial begin
    //              s t w f  blx  bly  fx   fy   n   st p l lvl lv w  ax   ay   r
    tbl[0]  = mkv(0,0,0,0, 100, 100,   0,   0,  1,  0,0,0, 0, 3,0,   0,   0, 16);
    tbl[1]  = mkv(1,0,0,0, 100, 100,   0,   0,  1,  1,1,1, 0, 3,0, 100, 100, 16);
    tbl[2]  = mkv(0,0,0,0,  50,  60,   0,   0,  1,  1,1,0, 0, 3,0,  50,  60, 16);
    tbl[3]  = mkv(1,0,0,0, 100, 100,   0,   0,  1,  1,1,0, 0, 3,0, 100, 100, 16);
    tbl[4]  = mkv(0,1,0,0, 100, 100,   0,   0,  1,  1,1,0, 0, 3,0, 100, 100, 16);
    tbl[5]  = mkv(0,0,0,1, 100, 100, 110,  96,  1,  2,0,0, 0, 3,0, 100, 100, 16);
    tbl[6]  = mkv(0,1,0,0, 100, 100, 110,  96, 15,  2,0,0, 0, 3,0, 110,  96,  1);
    tbl[7]  = mkv(0,0,1,0, 100, 100, 110,  96,  3,  2,0,0, 0, 3,0, 110,  96,  1);
    tbl[8]  = mkv(0,1,0,0, 100, 100, 110,  96,  1,  3,0,0, 0, 3,0, 110,  96,  0);
    tbl[9]  = mkv(0,1,0,0, 100, 100, 110,  96, 59,  3,0,0, 0, 3,0, 110,  96,  0);
    tbl[10] = mkv(0,1,0,0, 100, 100, 110,  96,  1,  1,1,1, 0, 2,0, 100, 100, 16);
    tbl[11] = mkv(0,0,0,0, 100, 100, 110,  96,  1,  1,1,0, 0, 2,0, 100, 100, 16);
    tbl[12] = mkv(0,0,1,1, 100, 100, 100, 100,  1,  2,0,0, 0, 2,1, 100, 100, 16);
    tbl[13] = mkv(0,1,0,0, 100, 100, 100, 100, 16,  3,0,0, 0, 2,1, 100, 100,  0);
    tbl[14] = mkv(0,1,0,0, 100, 100, 100, 100, 60,  1,1,1, 1, 2,1, 100, 100, 16);

    do_reset();
    for (int i = 0; i < 15; i++) begin
      start = tbl[i].start; tick = tbl[i].tick; win = tbl[i].win; fail = tbl[i].fail;
      bl_x = 10'(tbl[i].bl_x); bl_y = 10'(tbl[i].bl_y);
      fall_x = 10'(tbl[i].fall_x); fall_y = 10'(tbl[i].fall_y);
      cycles(tbl[i].n);
      chk($sformatf("vec%0d", i), tbl[i].e_state, tbl[i].e_play, tbl[i].e_load,
          tbl[i].e_level, tbl[i].e_lives, tbl[i].e_win, tbl[i].e_ax, tbl[i].e_ay, tbl[i].e_r);
    end
    start = 0; tick = 0; win = 0; fail = 0;

    // Four straight wins end the game.
    do_reset();
    start = 1; cycles(1); start = 0;
    for (int i = 0; i < MAX_LEVEL; i++) begin
      play_round(1'b1, 1'b0);
      if (i < MAX_LEVEL - 1) chk_val($sformatf("win%0d_level", i), int'(level), i + 1);
    end
    chk_val("wins_state_over", int'(state), 4);
    chk_val("wins_result", int'(result_win), 1);
    chk_val("wins_lives", int'(lives), INIT_LIVES);
    win = 1; cycles(1); win = 0;
    chk_val("over_ignores_win", int'(state), 4);
    start = 1; cycles(1); start = 0;
    chk("restart_after_over", 1, 1, 1, 0, INIT_LIVES, 1, 290, 210, RADIUS);

    // Three straight fails lose every life.
    do_reset();
    start = 1; cycles(1); start = 0;
    for (int i = 0; i < INIT_LIVES; i++) begin
      play_round(1'b0, 1'b1);
      chk_val($sformatf("fail%0d_lives", i), int'(lives), INIT_LIVES - 1 - i);
    end
    chk_val("fails_state_over", int'(state), 4);
    chk_val("fails_result", int'(result_win), 0);
    win = 1; tick = 1; cycles(3); win = 0; tick = 0;
    chk_val("over_ignores_win_tick", int'(state), 4);
    chk_val("over_lives_hold", int'(lives), 0);

    // Asynchronous reset in the middle of a fall.
    do_reset();
    start = 1; cycles(1); start = 0;
    bl_x = 10'd100; bl_y = 10'd100; fall_x = 10'd200; fall_y = 10'd200;
    fail = 1; cycles(1); fail = 0;
    tick = 1; cycles(5); tick = 0;
    chk("mid_fall", 2, 0, 0, 0, INIT_LIVES, 0, 105, 105, RADIUS - 5);
    #2 rst = 1'b0;
    #1 chk("async_reset", 0, 0, 0, 0, INIT_LIVES, 0, 0, 0, RADIUS);
    start = 1; cycles(2);
    chk_val("start_ignored_in_reset", int'(state), 0);
    rst = 1'b1; cycles(1); start = 0;
    chk("resume_after_reset", 1, 1, 1, 0, INIT_LIVES, 0, 100, 100, RADIUS);

    // Randomized run against the round model.
    do_reset();
    model_reset();
    for (int c = 0; c < 6000; c++) begin
      start  = ($urandom % 16) == 0;
      tick   = $urandom % 2;
      win    = ($urandom % 20) == 0;
      fail   = ($urandom % 12) == 0;
      bl_x   = 10'($urandom);
      bl_y   = 10'($urandom);
      fall_x = 10'($urandom);
      fall_y = 10'($urandom);
      @(posedge clk);
      model_step();
      #1;
      chk($sformatf("rand%0d", c), m_state, (m_state == 1) ? 1 : 0, m_load, m_level,
          m_lives, m_win, m_ax, m_ay, m_r);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
